sap_cpu_core: RTL and testbench
===============================

# sap_cpu_core

Parametrised SAP-style accumulator CPU core, successor to the fixed 8-bit/16-byte Tiny Tapeout CPU. It generalises data width and RAM depth and replaces the tri-state bus with a multiplexed internal datapath. It adds the behaviours the earlier core lacks: flag-driven conditional jumps, store-to-RAM, immediate load and halt, plus a valid/ready program-load handshake. It sits directly under the TT top wrapper, which maps ui_in/uio/uo_out onto its ports.

## Interface
- DATA_W, 8, data/instruction word width; must satisfy DATA_W >= ADDR_W+4
- ADDR_W, 4, RAM address width; RAM depth = 2^ADDR_W words

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- prog  in  1  program-load mode request
- prog_data  in  DATA_W  word to write into RAM
- prog_valid  in  1  prog_data valid
- prog_ready  out  1  core accepts a word this cycle
- done_load  out  1  all 2^ADDR_W words loaded
- out_data  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse when out_data updated by OUT
- carry  out  1  carry flag
- zero  out  1  zero flag
- halted  out  1  core stopped by HLT

## Operation
- Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand a = bits [ADDR_W-1:0]; other bits ignored.
- State machine: LOAD, FETCH, EXEC, HALT. Reset → LOAD.
- LOAD: prog_ready = prog & ~done_load. On prog_valid & prog_ready: RAM[ptr] <= prog_data, then ptr++. After the write to address 2^ADDR_W-1, done_load = 1 and ptr holds. Further words are not accepted. prog = 0 → FETCH; partial loads are allowed.
- FETCH: IR <= RAM[PC]; PC <= PC+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0) → EXEC.
- EXEC (RAM read combinational, M = RAM[a]) → FETCH, except HLT:
  - 0 NOP
  - 1 LDA: A <= M
  - 2 ADD: {C,A} <= A+M
  - 3 SUB: {C,A} <= A+~M+1 (C=1 means no borrow)
  - 4 STA: RAM[a] <= A
  - 5 LDI: A <= zero-extended a
  - 6 JMP: PC <= a
  - 7 JC: PC <= a if C
  - 8 JZ: PC <= a if Z
  - 9–D: reserved, execute as NOP
  - E OUT: out_data <= A, out_valid pulse
  - F HLT: → HALT
- Z <= (A result == 0). ADD and SUB are the only opcodes that write C and Z; the flags hold otherwise. JC/JZ test the flag values present before the jump executes.
- HALT: halted = 1. All inputs ignored until rst.
- Outside LOAD, prog/prog_valid are ignored and prog_ready = 0.
- Arithmetic is DATA_W bits, unsigned modulo 2^DATA_W; carry is bit DATA_W of the sum.

## Timing
- Reset values: state LOAD, PC 0, ptr 0, IR 0, A 0, C 0, Z 0, out_data 0, out_valid 0, halted 0, done_load 0. prog_ready follows prog combinationally after reset.
- RAM contents are NOT cleared by rst. Reset followed by prog = 0 reruns the stored program.
- rst mid-load or mid-execution takes priority over everything in that cycle. The in-flight write/STA is dropped.
- Every instruction takes 2 cycles (FETCH + EXEC). If prog is sampled 0 at edge k, FETCH of instruction n occurs at edge k+1+2n and its EXEC at edge k+2+2n.
- out_valid is high for exactly the one cycle following the OUT EXEC edge.
- done_load rises the cycle after the final accepted write. It stays high until rst.
- Registered outputs: out_data, out_valid, carry, zero, halted, done_load. prog_ready is combinational.

## Test plan
- Reset: assert rst 2 cycles with prog=0 → all outputs at reset values, prog_ready=0; raise prog → prog_ready=1 same cycle.
- Load handshake (8/4): 16 words with random prog_valid gaps → exactly 16 writes; done_load rises the cycle after the 16th. A 17th valid word gets prog_ready=0 and RAM is unchanged.
- Basic program: RAM0=0x1E, 1=0x2F, 2=0xE0, 3=0xF0, 14=0x07, 15=0x05; drop prog at edge k → out_data=0x0C with out_valid high only after edge k+6; halted=1 after edge k+8; C=0, Z=0.
- Flags/branch: RAM0=0x1E (M14=0xFF), 1=0x2F (M15=0x01), 2=0x75, 5=0xE0, 6=0xF0 → A=0x00, C=1, Z=1; JC taken; exactly one out_valid, out_data=0x00.
- SUB/STA: LDI 3, SUB 15 (M15=0x05), STA 13, LDA 13, OUT, HLT → out_data=0xFE, C=0, Z=0, RAM[13]=0xFE.
- Wrap/reset: all-NOP RAM → PC wraps 15→0 with no halt; rst mid-EXEC → LOAD with RAM retained; rerun with prog=0 gives identical out_data. Repeat the basic program with DATA_W=12, ADDR_W=6 → out_data=0x00C.

Source files
------------

// File: rtl/sap_cpu_if.sv
// Program-load handshake and status bus between the TT wrapper and the SAP core.
interface sap_cpu_if #(
    parameter int DATA_W = 8
);
    logic              prog;
    logic [DATA_W-1:0] prog_data;
    logic              prog_valid;
    logic              prog_ready;
    logic              done_load;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              carry;
    logic              zero;
    logic              halted;

    modport master (
        output prog, prog_data, prog_valid,
        input  prog_ready, done_load, out_data, out_valid, carry, zero, halted
    );

    modport slave (
        input  prog, prog_data, prog_valid,
        output prog_ready, done_load, out_data, out_valid, carry, zero, halted
    );
endinterface

// File: rtl/sap_cpu_core.sv
// SAP-style accumulator CPU: handshake program load, then FETCH/EXEC loop until HLT.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    sap_cpu_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    // RAM is deliberately outside the reset domain so a program survives rst.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ptr_q, ptr_d;
    // IR keeps only the fields that are decoded; the middle bits are don't-care.
    logic [3:0]        ir_op_q, ir_op_d;
    logic [ADDR_W-1:0] ir_a_q, ir_a_d;
    logic [DATA_W-1:0] a_q, a_d, out_q, out_d;
    logic              c_q, c_d, z_q, z_d, outv_q, outv_d, halt_q, halt_d, done_q, done_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata, m_word;
    logic [DATA_W:0]   sum, diff;
    logic              prog_ready_c;

    assign m_word = mem[ir_a_q];
    assign sum    = {1'b0, a_q} + {1'b0, m_word};
    // C=1 means no borrow: A + ~M + 1 in DATA_W+1 bits.
    assign diff   = {1'b0, a_q} + {1'b0, ~m_word} + {{DATA_W{1'b0}}, 1'b1};

    // Next-state, datapath and RAM-write decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ptr_d        = ptr_q;
        ir_op_d      = ir_op_q;
        ir_a_d       = ir_a_q;
        a_d          = a_q;
        c_d          = c_q;
        z_d          = z_q;
        out_d        = out_q;
        outv_d       = 1'b0;
        halt_d       = halt_q;
        done_d       = done_q;
        mem_we       = 1'b0;
        mem_waddr    = ptr_q;
        mem_wdata    = bus.prog_data;
        prog_ready_c = 1'b0;
        case (state_q)
            S_LOAD: begin
                prog_ready_c = bus.prog & ~done_q;
                if (!bus.prog) begin
                    state_d = S_FETCH;
                end else if (bus.prog_valid && prog_ready_c) begin
                    mem_we = 1'b1;
                    if (ptr_q == PTR_MAX) done_d = 1'b1;
                    else                  ptr_d  = ptr_q + ADDR_W'(1);
                end
            end
            S_FETCH: begin
                ir_op_d = mem[pc_q][DATA_W-1 -: 4];
                ir_a_d  = mem[pc_q][ADDR_W-1:0];
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_op_q)
                    4'h1: a_d = m_word;
                    4'h2: begin
                        {c_d, a_d} = sum;
                        z_d = (sum[DATA_W-1:0] == '0);
                    end
                    4'h3: begin
                        {c_d, a_d} = diff;
                        z_d = (diff[DATA_W-1:0] == '0);
                    end
                    4'h4: begin
                        mem_we    = 1'b1;
                        mem_waddr = ir_a_q;
                        mem_wdata = a_q;
                    end
                    4'h5: a_d = {{(DATA_W-ADDR_W){1'b0}}, ir_a_q};
                    4'h6: pc_d = ir_a_q;
                    4'h7: if (c_q) pc_d = ir_a_q;
                    4'h8: if (z_q) pc_d = ir_a_q;
                    4'hE: begin
                        out_d  = a_q;
                        outv_d = 1'b1;
                    end
                    4'hF: begin
                        state_d = S_HALT;
                        halt_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // State and architectural registers; rst overrides any in-flight update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            pc_q    <= '0;
            ptr_q   <= '0;
            ir_op_q <= '0;
            ir_a_q  <= '0;
            a_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            out_q   <= '0;
            outv_q  <= 1'b0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            ir_op_q <= ir_op_d;
            ir_a_q  <= ir_a_d;
            a_q     <= a_d;
            c_q     <= c_d;
            z_q     <= z_d;
            out_q   <= out_d;
            outv_q  <= outv_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
        end
    end

    // RAM write port shared by program load and STA; dropped while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.prog_ready = prog_ready_c;
    assign bus.done_load  = done_q;
    assign bus.out_data   = out_q;
    assign bus.out_valid  = outv_q;
    assign bus.carry      = c_q;
    assign bus.zero       = z_q;
    assign bus.halted     = halt_q;
endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed bench for sap_cpu_core: 8/4 instance for most tests, 12/6 instance for width scaling.
module tb_sap_cpu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   writes = 0;
    logic [7:0] img [16];

    always #5 clk = ~clk;

    sap_cpu_if #(.DATA_W(8))  bus8 ();
    sap_cpu_if #(.DATA_W(12)) bus12 ();

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus8));
    sap_cpu_core #(.DATA_W(12), .ADDR_W(6)) dut_w (.clk(clk), .rst(rst), .bus(bus12));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = 8'h00;
    endtask

    task automatic reset8();
        rst = 1'b1;
        bus8.prog = 1'b1;
        bus8.prog_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Loads img[] back to back, leaves prog high.
    task automatic load8();
        int i = 0;
        int guard = 0;
        logic acc;
        bus8.prog = 1'b1;
        while (i < 16 && guard < 100) begin
            bus8.prog_valid = 1'b1;
            bus8.prog_data  = img[i];
            #1;
            acc = bus8.prog_valid && bus8.prog_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        bus8.prog_valid = 1'b0;
        checks++;
        if (i != 16) begin
            failures++;
            $display("FAIL load8_count: accepted %0d want 16", i);
        end
    endtask

    // Drops prog and runs until halted, counting out_valid pulses.
    task automatic run_halt8(input int max_cyc, output int pulses, output logic [7:0] last);
        pulses = 0;
        last = 8'h00;
        bus8.prog = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            tick();
            if (bus8.out_valid) begin
                pulses++;
                last = bus8.out_data;
            end
            if (bus8.halted) break;
        end
        checks++;
        if (bus8.halted !== 1'b1) begin
            failures++;
            $display("FAIL run_timeout: halted=%b want 1 within %0d cycles", bus8.halted, max_cyc);
        end
    endtask

    task automatic set_basic();
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'h07; img[15] = 8'h05;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.prog = 1'b0;
        bus8.prog_valid = 1'b0;
        bus8.prog_data = 8'h00;
        tick();
        tick();
        checks += 7;
        if (bus8.out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data: got %h want 00", bus8.out_data); end
        if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", bus8.out_valid); end
        if (bus8.carry !== 1'b0)     begin failures++; $display("FAIL rst_carry: got %b want 0", bus8.carry); end
        if (bus8.zero !== 1'b0)      begin failures++; $display("FAIL rst_zero: got %b want 0", bus8.zero); end
        if (bus8.halted !== 1'b0)    begin failures++; $display("FAIL rst_halted: got %b want 0", bus8.halted); end
        if (bus8.done_load !== 1'b0) begin failures++; $display("FAIL rst_done_load: got %b want 0", bus8.done_load); end
        if (bus8.prog_ready !== 1'b0) begin failures++; $display("FAIL rst_prog_ready: got %b want 0", bus8.prog_ready); end
        bus8.prog = 1'b1;
        #1;
        checks++;
        if (bus8.prog_ready !== 1'b1) begin failures++; $display("FAIL rst_prog_ready_comb: got %b want 1", bus8.prog_ready); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        int i = 0;
        int guard = 0;
        int pulses;
        logic acc;
        logic [7:0] last;
        reset8();
        set_basic();
        writes = 0;
        while (i < 16 && guard < 300) begin
            if ($urandom_range(0, 2) == 0) begin
                bus8.prog_valid = 1'b0;
            end else begin
                bus8.prog_valid = 1'b1;
                bus8.prog_data  = img[i];
            end
            #1;
            acc = bus8.prog_valid && bus8.prog_ready;
            if (acc) writes++;
            if (acc && i == 15) begin
                checks++;
                if (bus8.done_load !== 1'b0) begin failures++; $display("FAIL load_done_early: got %b want 0", bus8.done_load); end
            end
            tick();
            if (acc) i++;
            guard++;
        end
        bus8.prog_valid = 1'b0;
        checks++;
        if (bus8.done_load !== 1'b1) begin failures++; $display("FAIL load_done_rise: got %b want 1", bus8.done_load); end
        // 17th word must be refused and must not land in RAM
        bus8.prog_valid = 1'b1;
        bus8.prog_data  = 8'hFF;
        #1;
        checks++;
        if (bus8.prog_ready !== 1'b0) begin failures++; $display("FAIL load_17th_ready: got %b want 0", bus8.prog_ready); end
        if (bus8.prog_valid && bus8.prog_ready) writes++;
        tick();
        bus8.prog_valid = 1'b0;
        checks++;
        if (writes != 16) begin failures++; $display("FAIL load_writes: got %0d want 16", writes); end
        run_halt8(100, pulses, last);
        checks++;
        if (last !== 8'h0C) begin failures++; $display("FAIL load_ram_intact: out %h want 0c", last); end
    endtask

    task automatic test_basic();
        reset8();
        set_basic();
        load8();
        bus8.prog = 1'b0;
        tick();  // edge k
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: edge k+%0d got %b want 0", e, bus8.out_valid); end
        end
        tick();  // k+6
        checks += 2;
        if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", bus8.out_valid); end
        if (bus8.out_data !== 8'h0C) begin failures++; $display("FAIL basic_out: got %h want 0c", bus8.out_data); end
        tick();  // k+7
        checks += 2;
        if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse: got %b want 0", bus8.out_valid); end
        if (bus8.halted !== 1'b0)    begin failures++; $display("FAIL basic_halt_early: got %b want 0", bus8.halted); end
        tick();  // k+8
        checks += 3;
        if (bus8.halted !== 1'b1) begin failures++; $display("FAIL basic_halt: got %b want 1", bus8.halted); end
        if (bus8.carry !== 1'b0)  begin failures++; $display("FAIL basic_carry: got %b want 0", bus8.carry); end
        if (bus8.zero !== 1'b0)   begin failures++; $display("FAIL basic_zero: got %b want 0", bus8.zero); end
        // HALT ignores inputs
        bus8.prog = 1'b1;
        bus8.prog_valid = 1'b1;
        #1;
        checks++;
        if (bus8.prog_ready !== 1'b0) begin failures++; $display("FAIL halt_prog_ready: got %b want 0", bus8.prog_ready); end
        tick();
        bus8.prog_valid = 1'b0;
        checks++;
        if (bus8.halted !== 1'b1) begin failures++; $display("FAIL halt_hold: got %b want 1", bus8.halted); end
    endtask

    task automatic test_flags_branch();
        int pulses;
        logic [7:0] last;
        reset8();
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h75; img[3] = 8'h59; img[4] = 8'hE0;
        img[5] = 8'hE0; img[6] = 8'hF0; img[14] = 8'hFF; img[15] = 8'h01;
        load8();
        run_halt8(100, pulses, last);
        checks += 4;
        if (pulses != 1)     begin failures++; $display("FAIL jc_pulses: got %0d want 1", pulses); end
        if (last !== 8'h00)  begin failures++; $display("FAIL jc_out: got %h want 00", last); end
        if (bus8.carry !== 1'b1) begin failures++; $display("FAIL jc_carry: got %b want 1", bus8.carry); end
        if (bus8.zero !== 1'b1)  begin failures++; $display("FAIL jc_zero: got %b want 1", bus8.zero); end
    endtask

    task automatic test_sub_sta();
        int pulses;
        logic [7:0] last;
        reset8();
        clear_img();
        img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'h4D; img[3] = 8'h50;
        img[4] = 8'h1D; img[5] = 8'hE0; img[6] = 8'hF0; img[15] = 8'h05;
        load8();
        run_halt8(100, pulses, last);
        checks += 4;
        if (pulses != 1)     begin failures++; $display("FAIL sub_pulses: got %0d want 1", pulses); end
        if (last !== 8'hFE)  begin failures++; $display("FAIL sub_sta_out: got %h want fe", last); end
        if (bus8.carry !== 1'b0) begin failures++; $display("FAIL sub_carry: got %b want 0", bus8.carry); end
        if (bus8.zero !== 1'b0)  begin failures++; $display("FAIL sub_zero: got %b want 0", bus8.zero); end
    endtask

    // SUB to zero sets Z, JZ taken, LDI afterwards leaves flags alone.
    task automatic test_jz();
        int pulses;
        logic [7:0] last;
        reset8();
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'h85; img[3] = 8'hE0; img[4] = 8'hF0;
        img[5] = 8'h5A; img[6] = 8'hE0; img[7] = 8'hF0; img[14] = 8'h01; img[15] = 8'h01;
        load8();
        run_halt8(100, pulses, last);
        checks += 4;
        if (pulses != 1)     begin failures++; $display("FAIL jz_pulses: got %0d want 1", pulses); end
        if (last !== 8'h0A)  begin failures++; $display("FAIL jz_out: got %h want 0a", last); end
        if (bus8.zero !== 1'b1)  begin failures++; $display("FAIL jz_zero_hold: got %b want 1", bus8.zero); end
        if (bus8.carry !== 1'b1) begin failures++; $display("FAIL jz_carry_hold: got %b want 1", bus8.carry); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        logic [7:0] last = 8'h00;
        reset8();
        clear_img();
        img[0] = 8'h57; img[15] = 8'hE0;
        load8();
        bus8.prog = 1'b0;
        tick();  // edge k
        for (int c = 0; c < 70; c++) begin
            tick();
            if (bus8.out_valid) begin
                pulses++;
                last = bus8.out_data;
            end
        end
        checks += 3;
        if (pulses != 2)      begin failures++; $display("FAIL wrap_pulses: got %0d want 2", pulses); end
        if (last !== 8'h07)   begin failures++; $display("FAIL wrap_out: got %h want 07", last); end
        if (bus8.halted !== 1'b0) begin failures++; $display("FAIL wrap_halted: got %b want 0", bus8.halted); end
    endtask

    task automatic test_reset_rerun();
        int pulses;
        logic [7:0] last;
        reset8();
        set_basic();
        load8();
        bus8.prog = 1'b0;
        tick();  // k
        tick();  // k+1 FETCH LDA
        tick();  // k+2 EXEC LDA
        tick();  // k+3 FETCH ADD
        rst = 1'b1;  // sampled on the EXEC ADD edge
        tick();
        tick();
        checks += 4;
        if (bus8.done_load !== 1'b0) begin failures++; $display("FAIL rerun_done_clr: got %b want 0", bus8.done_load); end
        if (bus8.carry !== 1'b0)     begin failures++; $display("FAIL rerun_carry: got %b want 0", bus8.carry); end
        if (bus8.out_data !== 8'h00) begin failures++; $display("FAIL rerun_out_clr: got %h want 00", bus8.out_data); end
        if (bus8.prog_ready !== 1'b0) begin failures++; $display("FAIL rerun_ready: got %b want 0", bus8.prog_ready); end
        rst = 1'b0;
        run_halt8(100, pulses, last);
        checks += 2;
        if (pulses != 1)    begin failures++; $display("FAIL rerun_pulses: got %0d want 1", pulses); end
        if (last !== 8'h0C) begin failures++; $display("FAIL rerun_out: got %h want 0c", last); end
    endtask

    task automatic test_wide();
        logic [11:0] wimg [16];
        int i = 0;
        int guard = 0;
        int pulses = 0;
        logic acc;
        logic [11:0] last = 12'h000;
        foreach (wimg[j]) wimg[j] = 12'h000;
        wimg[0] = 12'h10E; wimg[1] = 12'h20F; wimg[2] = 12'hE00; wimg[3] = 12'hF00;
        wimg[14] = 12'h007; wimg[15] = 12'h005;
        rst = 1'b1;
        bus12.prog = 1'b1;
        bus12.prog_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        while (i < 16 && guard < 100) begin
            bus12.prog_valid = 1'b1;
            bus12.prog_data  = wimg[i];
            #1;
            acc = bus12.prog_valid && bus12.prog_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        bus12.prog_valid = 1'b0;
        checks++;
        if (bus12.done_load !== 1'b0) begin failures++; $display("FAIL wide_partial_done: got %b want 0", bus12.done_load); end
        bus12.prog = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus12.out_valid) begin
                pulses++;
                last = bus12.out_data;
            end
            if (bus12.halted) break;
        end
        checks += 3;
        if (bus12.halted !== 1'b1) begin failures++; $display("FAIL wide_halt: got %b want 1", bus12.halted); end
        if (pulses != 1)           begin failures++; $display("FAIL wide_pulses: got %0d want 1", pulses); end
        if (last !== 12'h00C)      begin failures++; $display("FAIL wide_out: got %h want 00c", last); end
    endtask

    initial begin
        bus8.prog = 1'b0;
        bus8.prog_valid = 1'b0;
        bus8.prog_data = 8'h00;
        bus12.prog = 1'b0;
        bus12.prog_valid = 1'b0;
        bus12.prog_data = 12'h000;
        test_reset();
        test_load();
        test_basic();
        test_flags_branch();
        test_sub_sta();
        test_jz();
        test_wrap();
        test_reset_rerun();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
